multi_phase_traffic_controller: RTL
===================================

# multi_phase_traffic_controller

Parametrised successor to the two-approach traffic light controller. Serves `NUM_PHASES` conflicting vehicle phases in round-robin order and skips phases with no demand. Green time is sensor-actuated, with minimum, gap-out and max-out. Each phase has a latched pedestrian request that is served as a concurrent walk interval, and all outputs are decoded from registered state.

## Interface
- `NUM_PHASES`, 4: number of conflicting phases (2..8).
- `CNT_W`, 8: interval timer width; every time parameter must be below 2^CNT_W.
- `GREEN_MIN`, 10: minimum green cycles (≥1).
- `GREEN_MAX`, 40: max-out green cycles (≥ GREEN_MIN and ≥ WALK_TIME+PED_CLEAR_TIME).
- `YELLOW_TIME`, 4: yellow cycles (≥1).
- `ALL_RED_TIME`, 2: all-red clearance cycles (≥1).
- `WALK_TIME`, 6: WALK cycles.
- `PED_CLEAR_TIME`, 6: flashing-don't-walk cycles.
- `PW = max(1,$clog2(NUM_PHASES))`, local parameter.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `sensor`, in, NUM_PHASES: vehicle presence per phase; level.
- `ped_req`, in, NUM_PHASES: pedestrian push-button per phase; any high cycle is a request.
- `light`, out, 2*NUM_PHASES: phase i on bits [2i+1:2i]; 00 RED, 01 YELLOW, 10 GREEN; 11 never driven.
- `ped_signal`, out, 2*NUM_PHASES: 00 DONT_WALK, 01 WALK, 10 FLASH_DONT_WALK.
- `active_phase`, out, PW: phase currently in GREEN/YELLOW, or the last served phase while in ALL_RED.
- `ped_pending`, out, 1: OR of all pedestrian latches.

## Operation
- **States:** ALL_RED, GREEN, YELLOW. There is one interval timer `t` (CNT_W bits), zeroed on every state entry and incremented each cycle in state.
- **Reset values:**
  - state ALL_RED, t=0
  - `active_phase`=NUM_PHASES-1
  - every `light`=RED, every `ped_signal`=DONT_WALK
  - pedestrian latches cleared, `ped_pending`=0
  - `walk_srv`=0
- **ALL_RED:** every light is RED. When t==ALL_RED_TIME-1, select the next phase and enter GREEN.
  - Next phase is the first i searching from `active_phase`+1 (mod NUM_PHASES) where `sensor[i]` | latch[i] | `ped_req[i]`.
  - If no phase has demand, take `active_phase`+1 (recall).
  - The current phase is eligible only after the other phases have been searched, i.e. when it is the sole demand.
- **GREEN entry:**
  - `walk_srv` = latch[i] | `ped_req[i]`; latch[i] is cleared.
  - Effective minimum `min_eff` = `walk_srv` ? max(GREEN_MIN, WALK_TIME+PED_CLEAR_TIME) : GREEN_MIN.
- **GREEN:**
  - `light[i]`=GREEN; all other lights RED.
  - If `walk_srv`: `ped_signal[i]`=WALK for t<WALK_TIME, FLASH_DONT_WALK for WALK_TIME≤t<WALK_TIME+PED_CLEAR_TIME, then DONT_WALK.
  - Leave to YELLOW at the end of the cycle where (t ≥ min_eff-1 and `sensor[i]`==0) [gap-out], or t==GREEN_MAX-1 [max-out].
- **YELLOW:** `light[i]`=YELLOW and every `ped_signal` is DONT_WALK. When t==YELLOW_TIME-1, enter ALL_RED.
- **Pedestrian latches:**
  - latch[j] is set by `ped_req[j]` in any cycle and cleared only at phase j GREEN entry.
  - A request during phase j's own GREEN or YELLOW is held for phase j's next service.
  - Set and clear in the same cycle: the request is consumed by `walk_srv`.
- **Safety invariant:** at most one phase is non-RED in any cycle, and no WALK or FLASH_DONT_WALK appears on a phase that is not GREEN.

## Timing
- Outputs are pure decodes of registered state; there is no combinational path from input to output. Sensor and ped_req decisions take effect on the next clock edge.
- After reset release, phase 0 goes GREEN on the ALL_RED_TIME-th rising edge.
- Fixed-time cycle per served phase: green min_eff..GREEN_MAX cycles, then exactly YELLOW_TIME, then exactly ALL_RED_TIME.
- With defaults and no demand, the phase period is 10+4+2 = 16 cycles.
- `reset` asserted mid-interval forces the reset values immediately (asynchronously), with no yellow.
- t never wraps: every exit condition fires before 2^CNT_W-1.

## Test plan
- **Reset/idle:** defaults, inputs 0. Phases 0,1,2,3,0… each green for exactly 10 cycles, yellow 4, all-red 2; `light` is never 11.
- **Max-out:** `sensor[0]` held high. Phase 0 green for exactly 40 cycles, then yellow. With sensor dropped at green cycle 15, yellow starts after green cycle 15 (gap-out).
- **Skip:** only `sensor[2]`=1 while phase 0 is green. Next green is phase 2; phases 1 and 3 stay RED throughout.
- **Pedestrian:** 1-cycle `ped_req[1]` pulse while phase 3 is green. `ped_pending`=1 until phase 1 entry, then WALK for 6 cycles, FLASH_DONT_WALK for 6, and green lasts ≥12 cycles.
- **Own-phase request:** `ped_req[1]` during phase 1 green. No WALK in that interval, and the request is served at phase 1's next green.
- **Async reset:** assert `reset` mid-GREEN between clock edges. All outputs are at reset values before the next edge; the safety invariant is asserted every cycle of the run.

Source files
------------

// File: rtl/multi_phase_traffic_controller_if.sv
// Signal bundle between a traffic controller and its environment: detector and push-button
// inputs, decoded signal-head outputs.
interface multi_phase_traffic_controller_if #(
  parameter int unsigned NUM_PHASES = 4
);
  localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic [NUM_PHASES-1:0]   sensor;
  logic [NUM_PHASES-1:0]   ped_req;
  logic [2*NUM_PHASES-1:0] light;
  logic [2*NUM_PHASES-1:0] ped_signal;
  logic [PW-1:0]           active_phase;
  logic                    ped_pending;

  modport master (
    output sensor,
    output ped_req,
    input  light,
    input  ped_signal,
    input  active_phase,
    input  ped_pending
  );

  modport slave (
    input  sensor,
    input  ped_req,
    output light,
    output ped_signal,
    output active_phase,
    output ped_pending
  );
endinterface

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin actuated controller for NUM_PHASES conflicting phases with latched pedestrian
// requests served as a concurrent walk; outputs decode registered state only.
module multi_phase_traffic_controller #(
  parameter int unsigned NUM_PHASES     = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned GREEN_MIN      = 10,
  parameter int unsigned GREEN_MAX      = 40,
  parameter int unsigned YELLOW_TIME    = 4,
  parameter int unsigned ALL_RED_TIME   = 2,
  parameter int unsigned WALK_TIME      = 6,
  parameter int unsigned PED_CLEAR_TIME = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  multi_phase_traffic_controller_if.slave   bus
);
  localparam int unsigned PW       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int unsigned WALK_END = WALK_TIME + PED_CLEAR_TIME;
  localparam int unsigned PED_MIN  = (GREEN_MIN > WALK_END) ? GREEN_MIN : WALK_END;

  localparam logic [CNT_W-1:0] ALL_RED_LAST   = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] PED_MIN_LAST   = CNT_W'(PED_MIN - 1);
  localparam logic [CNT_W-1:0] WALK_T         = CNT_W'(WALK_TIME);
  localparam logic [CNT_W-1:0] WALK_END_T     = CNT_W'(WALK_END);

  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] PED_WALK     = 2'b01;
  localparam logic [1:0] PED_FLASH    = 2'b10;

  typedef enum logic [1:0] {StAllRed, StGreen, StYellow} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      t_q, t_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [NUM_PHASES-1:0] latch_q, latch_d;
  logic                  walk_srv_q, walk_srv_d;

  logic [NUM_PHASES-1:0] demand;
  logic [PW-1:0]         next_phase;
  logic [PW-1:0]         idx;
  logic                  found;
  logic [CNT_W-1:0]      min_last;

  assign demand   = bus.sensor | latch_q | bus.ped_req;
  assign min_last = walk_srv_q ? PED_MIN_LAST : GREEN_MIN_LAST;

  // Search starts after the last served phase; it is reached last, so it only wins when it is
  // the sole demand. No demand at all falls back to the recall phase.
  always_comb begin
    next_phase = PW'((32'(phase_q) + 32'd1) % NUM_PHASES);
    found      = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
      idx = PW'((32'(phase_q) + k) % NUM_PHASES);
      if (!found && demand[idx]) begin
        next_phase = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    t_d        = t_q + CNT_W'(1);
    phase_d    = phase_q;
    latch_d    = latch_q | bus.ped_req;
    walk_srv_d = walk_srv_q;
    unique case (state_q)
      StAllRed: begin
        if (t_q == ALL_RED_LAST) begin
          state_d             = StGreen;
          t_d                 = '0;
          phase_d             = next_phase;
          walk_srv_d          = latch_q[next_phase] | bus.ped_req[next_phase];
          latch_d[next_phase] = 1'b0;
        end
      end
      StGreen: begin
        if ((t_q >= min_last && !bus.sensor[phase_q]) || t_q == GREEN_MAX_LAST) begin
          state_d = StYellow;
          t_d     = '0;
        end
      end
      StYellow: begin
        if (t_q == YELLOW_LAST) begin
          state_d = StAllRed;
          t_d     = '0;
        end
      end
      default: begin
        state_d = StAllRed;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StAllRed;
      t_q        <= '0;
      phase_q    <= PW'(NUM_PHASES - 1);
      latch_q    <= '0;
      walk_srv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      phase_q    <= phase_d;
      latch_q    <= latch_d;
      walk_srv_q <= walk_srv_d;
    end
  end

  always_comb begin
    bus.light      = '0;
    bus.ped_signal = '0;
    unique case (state_q)
      StGreen: begin
        bus.light[{phase_q, 1'b0} +: 2] = LIGHT_GREEN;
        if (walk_srv_q) begin
          if (t_q < WALK_T) begin
            bus.ped_signal[{phase_q, 1'b0} +: 2] = PED_WALK;
          end else if (t_q < WALK_END_T) begin
            bus.ped_signal[{phase_q, 1'b0} +: 2] = PED_FLASH;
          end
        end
      end
      StYellow: bus.light[{phase_q, 1'b0} +: 2] = LIGHT_YELLOW;
      default: ;
    endcase
  end

  assign bus.active_phase = phase_q;
  assign bus.ped_pending  = |latch_q;
endmodule
